// File: rtl/dmem_responder.sv
// Wait-stated RV32I data-memory responder: IDLE -> WAIT -> ACCESS -> RESP.
// Define DMEM_MISALIGN_CHK_EN to reject misaligned accesses instead of aligning them down.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  localparam int AW =
    (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]  WC      = 4'(WAIT_CYCLES);
  localparam logic [31:0] DEPTH_L = 32'(DEPTH_WORDS);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACCESS,
    RESP
  } state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [2:0]  r_f3;
  logic [31:0] r_rdata;
  logic        r_err;
  logic        r_valid;

  logic [31:0] r_mem [DEPTH_WORDS];

  logic          w_is_b;
  logic          w_is_h;
  logic          w_is_w;
  logic          w_f3_err;
  logic          w_idx_err;
  logic          w_mis;
  logic          w_err;
  logic [1:0]    w_lane;
  logic [AW-1:0] w_idx;
  logic [31:0]   w_word;
  logic [7:0]    w_b;
  logic [15:0]   w_h;
  logic [31:0]   w_load;
  logic [31:0]   w_wdat;
  logic [3:0]    w_bmask;
  logic          w_mem_we;

  assign w_is_b = (r_f3[1:0] == 2'b00);
  assign w_is_h = (r_f3[1:0] == 2'b01);
  assign w_is_w = (r_f3[1:0] == 2'b10);

  always_comb begin
    w_f3_err = 1'b1;
    case (r_f3)
      3'b000, 3'b001, 3'b010: w_f3_err = 1'b0;
      3'b100, 3'b101:         w_f3_err = r_we;
      default:                w_f3_err = 1'b1;
    endcase
  end

  assign w_idx_err = ({2'b00, r_addr[31:2]} >= DEPTH_L);
  assign w_idx     = r_addr[AW+1:2];

`ifdef DMEM_MISALIGN_CHK_EN
  assign w_mis  = (w_is_h && r_addr[0]) ||
                  (w_is_w && (r_addr[1:0] != 2'b00));
  assign w_lane = r_addr[1:0];
`else
  // Misaligned halves/words are aligned down rather than rejected.
  assign w_mis  = 1'b0;
  assign w_lane = w_is_w ? 2'b00 :
                  w_is_h ? {r_addr[1], 1'b0} :
                  r_addr[1:0];
`endif

  assign w_err  = w_idx_err | w_f3_err | w_mis;
  assign w_word = r_mem[w_idx];

  always_comb begin
    w_b = w_word[7:0];
    case (w_lane)
      2'd0: w_b = w_word[7:0];
      2'd1: w_b = w_word[15:8];
      2'd2: w_b = w_word[23:16];
      2'd3: w_b = w_word[31:24];
      default: w_b = w_word[7:0];
    endcase
  end

  assign w_h = w_lane[1] ? w_word[31:16] : w_word[15:0];

  always_comb begin
    w_load = 32'h0;
    case (r_f3)
      3'b000:  w_load = {{24{w_b[7]}}, w_b};
      3'b001:  w_load = {{16{w_h[15]}}, w_h};
      3'b010:  w_load = w_word;
      3'b100:  w_load = {24'h0, w_b};
      3'b101:  w_load = {16'h0, w_h};
      default: w_load = 32'h0;
    endcase
  end

  always_comb begin
    w_wdat  = {4{r_wdata[7:0]}};
    w_bmask = 4'b0000;
    unique case (1'b1)
      w_is_w: begin
        w_wdat  = r_wdata;
        w_bmask = 4'b1111;
      end
      w_is_h: begin
        w_wdat  = {2{r_wdata[15:0]}};
        w_bmask = w_lane[1] ? 4'b1100 : 4'b0011;
      end
      w_is_b: begin
        w_wdat  = {4{r_wdata[7:0]}};
        w_bmask = 4'b0001 << w_lane;
      end
      default: begin
        w_wdat  = {4{r_wdata[7:0]}};
        w_bmask = 4'b0000;
      end
    endcase
  end

  assign w_mem_we = rst && (r_state == ACCESS) &&
                    r_we && !w_err;

  // Storage has no reset; contents survive rst.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (w_bmask[i]) begin
          r_mem[w_idx][i*8 +: 8] <= w_wdat[i*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_addr  <= 32'h0;
      r_wdata <= 32'h0;
      r_f3    <= 3'b000;
      r_rdata <= 32'h0;
      r_err   <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_we    <= req_we;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_f3    <= req_funct3;
            if (WC != 4'd0) begin
              r_cnt   <= WC;
              r_state <= WAIT;
            end else begin
              r_state <= ACCESS;
            end
          end
        end
        WAIT: begin
          if (r_cnt <= 4'd1) begin
            r_cnt   <= 4'd0;
            r_state <= ACCESS;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ACCESS: begin
          r_rdata <= (w_err || r_we) ? 32'h0 : w_load;
          r_err   <= w_err;
          r_valid <= 1'b1;
          r_state <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            r_rdata <= 32'h0;
            r_err   <= 1'b0;
            r_valid <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready  = (r_state == IDLE);
  assign busy       = (r_state != IDLE);
  assign resp_valid = r_valid;
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: directed requests push expectations,
// a monitor pops and checks each response, its latency and stall stability.
module tb_dmem_responder;

  localparam int WAIT_CYCLES = 1;
  localparam int DEPTH_WORDS = 256;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        busy;

  dmem_responder #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .WAIT_CYCLES(WAIT_CYCLES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_funct3(req_funct3),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err),
    .busy      (busy)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          hold;
    int          acc;
    int          id;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic issue(input logic we, input logic [31:0] a,
                       input logic [31:0] d, input logic [2:0] f3,
                       input logic [31:0] er, input logic ee,
                       input int hold, input int id, input bit push);
    int n;
    exp_t e;
    n = 0;
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_addr   = a;
    req_wdata  = d;
    req_funct3 = f3;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      n_vec++;
      n_bad++;
      $display("FAIL accept_timeout id %0d: req_ready 0 want 1", id);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    if (push) begin
      e.rdata = er;
      e.err   = ee;
      e.hold  = hold;
      e.acc   = cyc;
      e.id    = id;
      q.push_back(e);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst && resp_valid) begin
        if (q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_resp: rdata %h err %b", resp_rdata, resp_err);
        end else begin
          e = q.pop_front();
          chk($sformatf("latency_%0d", e.id), 32'(cyc - e.acc),
              32'(WAIT_CYCLES + 1));
          chk($sformatf("rdata_%0d", e.id), resp_rdata, e.rdata);
          chk($sformatf("err_%0d", e.id), {31'h0, resp_err}, {31'h0, e.err});
          if (e.hold > 0) begin
            resp_ready = 1'b0;
            repeat (e.hold) begin
              @(negedge clk);
              chk("stall_valid", {31'h0, resp_valid}, 32'h1);
              chk("stall_rdata", resp_rdata, e.rdata);
              chk("stall_req_ready", {31'h0, req_ready}, 32'h0);
              chk("stall_busy", {31'h0, busy}, 32'h1);
            end
            resp_ready = 1'b1;
          end
        end
        @(posedge clk);
      end
    end
  end

  initial begin
    int n;
    logic [31:0] w13;
    logic        e13;
    rst        = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    req_funct3 = 3'b000;
    resp_ready = 1'b1;
    #3;
    chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_err", {31'h0, resp_err}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rel_req_ready", {31'h0, req_ready}, 32'h1);

    issue(1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 32'h0, 1'b0, 0, 1, 1'b1);
    issue(1'b0, 32'h10, 32'h0, 3'b010, 32'hDEADBEEF, 1'b0, 0, 2, 1'b1);
    issue(1'b1, 32'h11, 32'h80, 3'b000, 32'h0, 1'b0, 0, 3, 1'b1);
    issue(1'b0, 32'h11, 32'h0, 3'b000, 32'hFFFFFF80, 1'b0, 0, 4, 1'b1);
    issue(1'b0, 32'h11, 32'h0, 3'b100, 32'h00000080, 1'b0, 0, 5, 1'b1);
    issue(1'b0, 32'h10, 32'h0, 3'b010, 32'hDEAD80EF, 1'b0, 0, 6, 1'b1);
    issue(1'b0, 32'h10, 32'h0, 3'b010, 32'hDEAD80EF, 1'b0, 5, 7, 1'b1);
    issue(1'b0, 32'h400, 32'h0, 3'b010, 32'h0, 1'b1, 0, 8, 1'b1);
    issue(1'b1, 32'h10, 32'h12345678, 3'b011, 32'h0, 1'b1, 0, 9, 1'b1);
    issue(1'b0, 32'h10, 32'h0, 3'b010, 32'hDEAD80EF, 1'b0, 0, 10, 1'b1);
    issue(1'b0, 32'h12, 32'h0, 3'b001, 32'hFFFFDEAD, 1'b0, 0, 11, 1'b1);
    issue(1'b0, 32'h12, 32'h0, 3'b101, 32'h0000DEAD, 1'b0, 0, 12, 1'b1);
    issue(1'b0, 32'h10, 32'h0, 3'b011, 32'h0, 1'b1, 0, 13, 1'b1);
    issue(1'b0, 32'h10, 32'h0, 3'b110, 32'h0, 1'b1, 0, 14, 1'b1);

`ifdef DMEM_MISALIGN_CHK_EN
    e13 = 1'b1;
    w13 = 32'hDEAD80EF;
`else
    e13 = 1'b0;
    w13 = 32'hBEEF80EF;
`endif
    issue(1'b1, 32'h13, 32'h0000BEEF, 3'b001, 32'h0, e13, 0, 15, 1'b1);
    issue(1'b0, 32'h10, 32'h0, 3'b010, w13, 1'b0, 0, 16, 1'b1);

    issue(1'b1, 32'h20, 32'h11223344, 3'b010, 32'h0, 1'b0, 0, 17, 1'b1);
    issue(1'b0, 32'h20, 32'h0, 3'b010, 32'h11223344, 1'b0, 0, 18, 1'b1);
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    issue(1'b1, 32'h20, 32'hCAFEF00D, 3'b010, 32'h0, 1'b0, 0, 19, 1'b0);
    rst = 1'b0;
    #2;
    chk("midrst_valid", {31'h0, resp_valid}, 32'h0);
    chk("midrst_busy", {31'h0, busy}, 32'h0);
    chk("midrst_rdata", resp_rdata, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("postrst_no_resp", {31'h0, resp_valid}, 32'h0);
    end
    issue(1'b0, 32'h20, 32'h0, 3'b010, 32'h11223344, 1'b0, 0, 20, 1'b1);

    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain_timeout: %0d pending want 0", q.size());
    end
    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, which is the number of 32-bit storage words.
REQ-002 SHALL have parameter WAIT_CYCLES, default 1, range 0..15, which is the number of wait states inserted before each access.
REQ-003 SHALL have port clk, input, width 1: the single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst, input, width 1: reset, asynchronous and active-low.
REQ-005 SHALL have port req_valid, input, width 1: the requester presents a request.
REQ-006 SHALL have port req_ready, output, width 1: the responder accepts a request.
REQ-007 SHALL have port req_we, input, width 1: 1 = store, 0 = load.
REQ-008 SHALL have port req_addr, input, width 32: byte address.
REQ-009 SHALL have port req_wdata, input, width 32: store data, right-aligned.
REQ-010 SHALL have port req_funct3, input, width 3: RV32I load/store size and sign code.
REQ-011 SHALL have port resp_valid, output, width 1: a response is presented.
REQ-012 SHALL have port resp_ready, input, width 1: the requester takes the response.
REQ-013 SHALL have port resp_rdata, output, width 32: load result after extension; 0 for stores and errors.
REQ-014 SHALL have port resp_err, output, width 1: the request was rejected and had no side effect.
REQ-015 SHALL have port busy, output, width 1: high in any state other than IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT, ACCESS and RESP.
REQ-017 SHALL drive req_ready = 1 only in IDLE.
REQ-018 SHALL, on accept (req_valid && req_ready at an edge), capture we, addr, wdata and funct3, then go to WAIT if WAIT_CYCLES > 0, else to ACCESS.
REQ-019 SHALL stay in WAIT for exactly WAIT_CYCLES cycles using a down-counter, then go to ACCESS.
REQ-020 SHALL, in ACCESS, perform the memory read or write in one cycle, register rdata and err, then go to RESP.
REQ-021 SHALL drive resp_valid = 1 in RESP and hold resp_rdata and resp_err stable until resp_ready = 1 at an edge, then go to IDLE.
REQ-022 SHALL raise resp_valid exactly WAIT_CYCLES+1 edges after the accept edge.
REQ-023 SHALL allow at most one outstanding request; no new accept is possible in the cycle a response retires.
REQ-024 SHALL use little-endian byte lanes, with word index = addr[31:2] and lane = addr[1:0].
REQ-025 SHALL support loads by funct3: 000 LB sign-extended; 001 LH sign-extended; 010 LW; 100 LBU zero-extended; 101 LHU zero-extended.
REQ-026 SHALL support stores by funct3: 000 SB writes wdata[7:0] to the addressed lane; 001 SH writes wdata[15:0]; 010 SW writes 32 bits; other bytes in the word are untouched.
REQ-027 SHALL treat any other funct3 value as an error.
REQ-028 SHALL treat word index >= DEPTH_WORDS as an error.
REQ-029 SHALL, on any error, set resp_err = 1 and resp_rdata = 0 and perform no write.
REQ-030 SHALL hold resp_rdata = 0 and resp_err = 0 when not in RESP.

Reset
REQ-031 SHALL, on rst low and regardless of clk, force state IDLE, req_ready = 1 after release, resp_valid = 0, resp_rdata = 0, resp_err = 0, busy = 0 and wait counter = 0.
REQ-032 SHALL, if reset is asserted mid-operation, discard the in-flight request; a store not yet in ACCESS is never committed and no response is produced.
REQ-033 SHALL NOT reset storage contents.

Configuration
REQ-034 SHALL, with macro DMEM_MISALIGN_CHK_EN defined, flag a misaligned access as an error (LH/LHU/SH with addr[0] = 1; LW/SW with addr[1:0] != 0), with no write.
REQ-035 SHALL, without DMEM_MISALIGN_CHK_EN, not flag misaligned accesses; the offending low address bits are forced to 0 (aligned down) and the access completes normally.

Verification
REQ-036 SHALL pass: WAIT_CYCLES = 1, SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> rdata 0xDEADBEEF, err 0, resp_valid 2 edges after each accept.
REQ-037 SHALL pass: after REQ-036, SB addr 0x11 data 0x80; LB 0x11 -> 0xFFFFFF80; LBU 0x11 -> 0x00000080; LW 0x10 -> 0xDEAD80EF.
REQ-038 SHALL pass: resp_ready held low for 5 cycles -> resp_valid and rdata stable for 5 cycles; req_ready = 0 and busy = 1 throughout.
REQ-039 SHALL pass: LW addr 0x400 with DEPTH_WORDS = 256 -> err 1, rdata 0; an invalid-funct3 store (011) -> err 1, memory unchanged.
REQ-040 SHALL pass: with DMEM_MISALIGN_CHK_EN, SH addr 0x13 -> err 1, no write; without it, the same SH writes lane 2 of word 4.
REQ-041 SHALL pass: rst low during WAIT of an SW to 0x20 -> no resp_valid; a later LW 0x20 returns the prior value.
